// File: rtl/refresh_scheduler_pkg.sv
// Shared types, default parameters and parameter sanity check for the refresh scheduler.
package mem_refresh_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        URGENT = 2'd2
    } ref_state_t;

    localparam int unsigned PCNT_W            = 16;
    localparam int unsigned DEF_TICKS_PER_REF = 4;
    localparam int unsigned DEF_PEND_W        = 4;
    localparam int unsigned DEF_MAX_PENDING   = 8;
    localparam int unsigned DEF_URGENT_LEVEL  = 6;

    // True when URGENT_LEVEL <= MAX_PENDING < 2^PEND_W and every value is in its legal range.
    function automatic bit params_ok(input int unsigned ticks_per_ref,
                                     input int unsigned pend_w,
                                     input int unsigned max_pending,
                                     input int unsigned urgent_level);
        return (ticks_per_ref >= 1) && (ticks_per_ref <= 65535) &&
               (pend_w >= 1) && (pend_w <= 31) &&
               (max_pending >= 1) && (max_pending < (32'd1 << pend_w)) &&
               (urgent_level >= 1) && (urgent_level <= max_pending);
    endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Request/acknowledge bundle between the refresh scheduler and the memory controller.
interface refresh_scheduler_if #(
    parameter int unsigned PEND_W = 4
);
    logic              en;
    logic              tick;
    logic              ref_ack;
    logic              clr_err;
    logic              ref_req;
    logic              ref_urgent;
    logic [PEND_W-1:0] pending;
    logic              ovf_err;
    logic              ack_err;

    modport master (
        output en, tick, ref_ack, clr_err,
        input  ref_req, ref_urgent, pending, ovf_err, ack_err
    );

    modport slave (
        input  en, tick, ref_ack, clr_err,
        output ref_req, ref_urgent, pending, ovf_err, ack_err
    );
endinterface

// File: rtl/refresh_scheduler.sv
// Prescales divider ticks into refresh-due events, accumulates them in a saturating
// pending counter and presents a registered level request with an urgency flag.
module refresh_scheduler
    import mem_refresh_pkg::*;
#(
    parameter int unsigned TICKS_PER_REF = DEF_TICKS_PER_REF,
    parameter int unsigned PEND_W        = DEF_PEND_W,
    parameter int unsigned MAX_PENDING   = DEF_MAX_PENDING,
    parameter int unsigned URGENT_LEVEL  = DEF_URGENT_LEVEL
) (
    input  logic                clk,
    input  logic                reset_n,
    refresh_scheduler_if.slave  bus
);

    if (!params_ok(TICKS_PER_REF, PEND_W, MAX_PENDING, URGENT_LEVEL)) begin : g_param_check
        $error("refresh_scheduler: illegal parameter combination");
    end

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    ref_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              urg_q, urg_d;
    logic              ovf_q, ovf_d;
    logic              aerr_q, aerr_d;
    logic              due;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q    <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
            req_q     <= 1'b0;
            urg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            aerr_q    <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            pending_q <= pending_d;
            state_q   <= state_d;
            req_q     <= req_d;
            urg_q     <= urg_d;
            ovf_q     <= ovf_d;
            aerr_q    <= aerr_d;
        end
    end

    always_comb begin
        pcnt_d    = pcnt_q;
        pending_d = pending_q;
        state_d   = state_q;
        due       = 1'b0;
        // An error raised this cycle outranks a simultaneous clear.
        ovf_d     = ovf_q  & ~bus.clr_err;
        aerr_d    = aerr_q & ~bus.clr_err;

        if (bus.tick && bus.en) begin
            if (pcnt_q == PCNT_W'(TICKS_PER_REF - 1)) begin
                pcnt_d = '0;
                due    = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PCNT_W'(1);
            end
        end

        // Due and ack in the same cycle cancel, even at the counter limits.
        case ({due, bus.ref_ack})
            2'b10: begin
                if (pending_q == PEND_W'(MAX_PENDING)) ovf_d = 1'b1;
                else                                    pending_d = pending_q + PEND_W'(1);
            end
            2'b01: begin
                if (pending_q == '0) aerr_d = 1'b1;
                else                 pending_d = pending_q - PEND_W'(1);
            end
            default: ;
        endcase

        if (pending_d == '0)                           state_d = IDLE;
        else if (pending_d >= PEND_W'(URGENT_LEVEL))   state_d = URGENT;
        else                                           state_d = REQ;

        req_d = (state_d != IDLE);
        urg_d = (state_d == URGENT);
    end

    assign bus.ref_req    = req_q;
    assign bus.ref_urgent = urg_q;
    assign bus.pending    = pending_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.ack_err    = aerr_q;

endmodule
